srl_step_ctrl: RTL and testbench

Upstream control stage for the MegaWing Spartan-3 shift-register test designs. It turns a raw push-button and a raw data switch into a clean single-step shift for a 32-deep SRL chain: a one-cycle `SHIFT_CE` pulse and a stable `SHIFT_D` bit. Both inputs are synchronised and the button is debounced. The block also keeps a 5-bit count of shifts performed, so the LED display can show the current fill position of the 32-entry SRL.

---
 rtl/srl_step_ctrl.sv | 138 +++++++++++++
 tb/tb_srl_step_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/srl_step_ctrl.sv
// Single-step shift control for a 32-deep SRL: synchronises BUTTON/DIN, debounces the button, issues one SHIFT_CE per press.
// Optional auto-repeat while held is enabled by defining SRL_STEP_AUTOREPEAT_EN.
module srl_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       CLKIN,
    input  logic       RESETN,
    input  logic       BUTTON,
    input  logic       DIN,
    output logic       SHIFT_CE,
    output logic       SHIFT_D,
    output logic [4:0] STEP_COUNT,
    output logic       PRESSED
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("srl_step_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       btn_sync_q, din_sync_q;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d;
    logic             ce_q, d_q, pressed_q;
    logic [4:0]       step_cnt_q;
    logic             step;
    logic             btn_s, din_s;

    assign btn_s = btn_sync_q[1];
    assign din_s = din_sync_q[1];

`ifdef SRL_STEP_AUTOREPEAT_EN
    localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_CYCLES - 1);

    logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        step     = 1'b0;
`ifdef SRL_STEP_AUTOREPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = PRESS;
                    db_cnt_d = '0;
                end
            end
            PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = HELD;
                    step    = 1'b1;
`ifdef SRL_STEP_AUTOREPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Release check wins over a repeat step landing on the same cycle.
                if (!btn_s) begin
                    state_d  = RELEASE;
                    db_cnt_d = '0;
                end
`ifdef SRL_STEP_AUTOREPEAT_EN
                else if (rpt_cnt_q == RP_LAST) begin
                    step      = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            btn_sync_q <= '0;
            din_sync_q <= '0;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            ce_q       <= 1'b0;
            d_q        <= 1'b0;
            step_cnt_q <= '0;
            pressed_q  <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], BUTTON};
            din_sync_q <= {din_sync_q[0], DIN};
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            ce_q       <= step;
            pressed_q  <= (state_d == HELD) || (state_d == RELEASE);
            if (step) begin
                d_q        <= din_s;
                step_cnt_q <= step_cnt_q + 5'd1;
            end
        end
    end

`ifdef SRL_STEP_AUTOREPEAT_EN
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign SHIFT_CE   = ce_q;
    assign SHIFT_D    = d_q;
    assign STEP_COUNT = step_cnt_q;
    assign PRESSED    = pressed_q;

endmodule

// File: tb/tb_srl_step_ctrl.sv
// Scoreboard bench for srl_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_srl_step_ctrl;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       btn  = 1'b1;
    logic       din  = 1'b1;
    logic       SHIFT_CE, SHIFT_D, PRESSED;
    logic [4:0] STEP_COUNT;

    srl_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8)
    ) dut (
        .CLKIN     (clk),
        .RESETN    (rstn),
        .BUTTON    (btn),
        .DIN       (din),
        .SHIFT_CE  (SHIFT_CE),
        .SHIFT_D   (SHIFT_D),
        .STEP_COUNT(STEP_COUNT),
        .PRESSED   (PRESSED)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         ecyc;
        logic       d;
        logic [4:0] cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_cnt = 5'd0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, ecnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_step(input int at_edge, input logic d);
        exp_cnt = exp_cnt + 5'd1;
        sb.push_back('{ecyc: at_edge, d: d, cnt: exp_cnt});
    endtask

    task automatic do_reset();
        tick(1);
        rstn = 1'b0;
        btn  = 1'b0;
        tick(2);
        rstn    = 1'b1;
        exp_cnt = 5'd0;
        tick(2);
    endtask

    // Expected pulse: first sampling edge is ecnt+1, step lands 6 edges later.
    task automatic press(input logic d, input int hold, input int gap);
        din = d;
        btn = 1'b1;
        push_step(ecnt + 7, d);
        tick(hold);
        chk("pressed_hold", int'(PRESSED), 1);
        btn = 1'b0;
        tick(gap);
        chk("pressed_rel", int'(PRESSED), 0);
        chk("d_hold", int'(SHIFT_D), int'(d));
    endtask

    always @(negedge clk) begin
        if (SHIFT_CE) begin
            if (sb.size() == 0) begin
                chk("unexpected_ce", int'(SHIFT_CE), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ce_edge", ecnt, mon_e.ecyc);
                chk("shift_d", int'(SHIFT_D), int'(mon_e.d));
                chk("step_count", int'(STEP_COUNT), int'(mon_e.cnt));
            end
        end
    end

    initial begin
        int base;

        // Reset held with button and data high
        tick(3);
        chk("rst_ce", int'(SHIFT_CE), 0);
        chk("rst_d", int'(SHIFT_D), 0);
        chk("rst_cnt", int'(STEP_COUNT), 0);
        chk("rst_pressed", int'(PRESSED), 0);
        rstn    = 1'b1;
        exp_cnt = 5'd0;
        push_step(ecnt + 7, 1'b1);
        tick(20);
        btn = 1'b0;
        tick(12);
        chk("rst_pending", sb.size(), 0);

        // Clean press
        do_reset();
        press(1'b1, 30, 12);
        chk("clean_count", int'(STEP_COUNT), 1);
        chk("clean_pending", sb.size(), 0);

        // Bounce on press
        do_reset();
        din = 1'b1;
        repeat (3) begin
            btn = 1'b1;
            tick(2);
            btn = 1'b0;
            tick(1);
        end
        tick(20);
        chk("bounce_count", int'(STEP_COUNT), 0);
        chk("bounce_pressed", int'(PRESSED), 0);

        // Short low glitch while held
        din = 1'b0;
        btn = 1'b1;
        push_step(ecnt + 7, 1'b0);
        tick(12);
        btn = 1'b0;
        tick(2);
        btn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("glitch_pressed", int'(PRESSED), 1);
        end
        btn = 1'b0;
        tick(12);
        chk("glitch_count", int'(STEP_COUNT), 1);
        chk("glitch_pending", sb.size(), 0);

        // Wrap over 33 presses
        do_reset();
        for (int i = 0; i < 33; i++) begin
            press(i[0], 8, 10);
            chk("wrap_track", int'(STEP_COUNT), int'(exp_cnt));
            if (i == 30) chk("wrap_31", int'(STEP_COUNT), 31);
            if (i == 31) chk("wrap_0", int'(STEP_COUNT), 0);
            if (i == 32) chk("wrap_1", int'(STEP_COUNT), 1);
        end
        chk("wrap_pending", sb.size(), 0);

`ifdef SRL_STEP_AUTOREPEAT_EN
        do_reset();
        din  = 1'b1;
        btn  = 1'b1;
        base = ecnt;
        for (int k = 0; k < 5; k++) push_step(base + 7 + 8 * k, 1'b1);
        tick(40);
        btn = 1'b0;
        tick(12);
        chk("rpt_count", int'(STEP_COUNT), 5);
        chk("rpt_pending", sb.size(), 0);
`endif

        // Reset during debounce with the button still down
        do_reset();
        din = 1'b1;
        btn = 1'b1;
        tick(5);
        rstn = 1'b0;
        tick(1);
        chk("mid_rst_ce", int'(SHIFT_CE), 0);
        chk("mid_rst_cnt", int'(STEP_COUNT), 0);
        tick(2);
        rstn    = 1'b1;
        exp_cnt = 5'd0;
        base    = ecnt;
        push_step(base + 7, 1'b1);
        tick(20);
        btn = 1'b0;
        tick(12);
        chk("mid_rst_count", int'(STEP_COUNT), 1);
        chk("mid_rst_pending", sb.size(), 0);

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
